div_unit: RTL and testbench

Multi-cycle 32-bit integer divider for the RV32M execute stage; the division counterpart to the single-cycle add/subtract datapath. It implements DIV, DIVU, REM and REMU with RISC-V semantics. It uses a radix-2 restoring algorithm: one 33-bit trial subtraction per cycle. The execute stage stalls on `busy` and captures `result` on `done`.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 21 ++
 rtl/div_unit.sv | 158 +++++++++++++++
 tb/tb_div_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV32M multi-cycle divider: op encodings, FSM states,
// iteration count and a magnitude helper.
package div_pkg;

    localparam int DIV_STEPS = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SIGN = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // Two's-complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift the partial remainder left by one quotient
// bit and keep the 33-bit trial difference when it does not borrow.
module div_step (
    input  logic [31:0] i_rem,
    input  logic        i_quo_msb,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_rem,
    output logic        o_qbit
);

    logic [32:0] w_shifted;
    logic [32:0] w_trial;

    assign w_shifted = {i_rem, i_quo_msb};
    assign w_trial   = w_shifted - {1'b0, i_divisor};

    // The partial remainder stays below the divisor, so bit 32 of the trial acts as its sign.
    assign o_qbit = ~w_trial[32];
    assign o_rem  = o_qbit ? w_trial[31:0] : w_shifted[31:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes |x| < |y| at accept instead of iterating.
module div_unit
    import div_pkg::*;
#(
    parameter int OP_W = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     x,
    input  logic [31:0]     y,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [31:0]     result
);

    div_state_t  r_state;
    logic [1:0]  r_op;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_div;
    logic        r_qneg;
    logic        r_rneg;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_result;

    logic [1:0]  w_op;
    logic        w_signed;
    logic        w_is_rem;
    logic [31:0] w_x_mag;
    logic [31:0] w_y_mag;
    logic        w_div0;
    logic        w_ovf;
    logic        w_early;
    logic        w_fast;
    logic [31:0] w_fast_res;
    logic [31:0] w_next_rem;
    logic        w_qbit;

    assign w_op     = op[1:0];
    assign w_signed = ~w_op[0];
    assign w_is_rem = w_op[1];
    assign w_x_mag  = w_signed ? mag32(x) : x;
    assign w_y_mag  = w_signed ? mag32(y) : y;
    assign w_div0   = (y == 32'd0);
    assign w_ovf    = w_signed && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (w_x_mag < w_y_mag);
`else
    assign w_early = 1'b0;
`endif

    assign w_fast = w_div0 | w_ovf | w_early;

    // Results that are known at accept; divide-by-zero outranks overflow, which outranks early-out.
    // NOTE: every signal assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        w_fast_res = 32'd0;
        if (w_div0) begin
            w_fast_res = w_is_rem ? x : 32'hFFFF_FFFF;
        end else if (w_ovf) begin
            w_fast_res = w_is_rem ? 32'd0 : 32'h8000_0000;
        end else if (w_early) begin
            w_fast_res = w_is_rem ? x : 32'd0;
        end
    end

    div_step u_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[31]),
        .i_divisor (r_div),
        .o_rem     (w_next_rem),
        .o_qbit    (w_qbit)
    );

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_rem    <= 32'd0;
            r_quo    <= 32'd0;
            r_div    <= 32'd0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_cnt    <= 5'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op   <= w_op;
                        r_qneg <= w_signed & (x[31] ^ y[31]);
                        r_rneg <= w_signed & x[31];
                        r_rem  <= 32'd0;
                        r_quo  <= w_x_mag;
                        r_div  <= w_y_mag;
                        r_cnt  <= 5'(DIV_STEPS - 1);
                        r_busy <= 1'b1;
                        if (w_fast) begin
                            r_result <= w_fast_res;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_next_rem;
                    r_quo <= {r_quo[30:0], w_qbit};
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    if (r_op[1]) begin
                        r_result <= r_rneg ? (~r_rem + 32'd1) : r_rem;
                    end else begin
                        r_result <= r_qneg ? (~r_quo + 32'd1) : r_quo;
                    end
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, hand-written flush/reset/start
// sequences, and random operations checked against a plain-arithmetic reference.
module tb_div_unit;
    import div_pkg::*;

`ifdef DIV_EARLY_OUT_EN
    localparam int LAT_EARLY = 1;
`else
    localparam int LAT_EARLY = 34;
`endif
    localparam int LAT_FULL = 34;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] x = 32'd0;
    logic [31:0] y = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] res;
        int          lat;
    } vec_t;

    div_unit #(.OP_W(2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V division rules expressed with ordinary integer arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output int lat);
        longint      sa, sb, q, r, ma, mb;
        logic [31:0] q32, r32;
        bit          sgn, want_rem;
        sgn      = (o == OP_DIV) || (o == OP_REM);
        want_rem = (o == OP_REM) || (o == OP_REMU);
        if (b == 32'd0) begin
            q32 = 32'hFFFF_FFFF;
            r32 = a;
            lat = 1;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q32 = 32'h8000_0000;
            r32 = 32'd0;
            lat = 1;
        end else if (sgn) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            q32 = q[31:0];
            r32 = r[31:0];
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            lat = (ma < mb) ? LAT_EARLY : LAT_FULL;
        end else begin
            q32 = a / b;
            r32 = a % b;
            lat = (a < b) ? LAT_EARLY : LAT_FULL;
        end
        res = want_rem ? r32 : q32;
    endfunction

    // Called #1 after an edge; returns #1 after the edge that ends the cycle where done is seen.
    task automatic wait_done(output int lat, output bit seen);
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        seen = done;
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        op    = o;
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, seen);
        check({name, "/done_seen"}, 32'(seen), 32'd1);
        check({name, "/latency"}, 32'(lat), 32'(exp_lat));
        check({name, "/result"}, result, exp_res);
        check({name, "/busy_in_done"}, {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check({name, "/idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit saw;
        saw = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        check(name, 32'(saw), 32'd0);
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] exp_res;
        int          exp_lat;
        int          lat;
        bit          seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", {31'd0, busy}, 32'd0);
        check("reset/done", {31'd0, done}, 32'd0);
        check("reset/result", result, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        vecs.push_back('{"div_100_7",    OP_DIV,  32'd100,        32'd7,          32'd14,         LAT_FULL});
        vecs.push_back('{"rem_100_7",    OP_REM,  32'd100,        32'd7,          32'd2,          LAT_FULL});
        vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  LAT_FULL});
        vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  LAT_FULL});
        vecs.push_back('{"divu_5_0",     OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1});
        vecs.push_back('{"remu_5_0",     OP_REMU, 32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1});
        vecs.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1});
        vecs.push_back('{"divu_3_10",    OP_DIVU, 32'd3,          32'd10,         32'd0,          LAT_EARLY});
        vecs.push_back('{"rem_m5_100",   OP_REM,  32'hFFFF_FFFB,  32'd100,        32'hFFFF_FFFB,  LAT_EARLY});
        vecs.push_back('{"div_7_m2",     OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  LAT_FULL});
        vecs.push_back('{"remu_max_16",  OP_REMU, 32'hFFFF_FFFF,  32'd16,         32'd15,         LAT_FULL});
        vecs.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  LAT_FULL});
        vecs.push_back('{"div_min_2",    OP_DIV,  32'h8000_0000,  32'd2,          32'hC000_0000,  LAT_FULL});
        vecs.push_back('{"rem_div0_neg", OP_REM,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  1});

        // Back-to-back: each run_op issues its start in the first idle cycle after the last one.
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].res, vecs[i].lat);
        end

        // Flush mid-operation: prior result is 14 from the next line.
        run_op("pre_flush", OP_DIV, 32'd100, 32'd7, 32'd14, LAT_FULL);
        op = OP_DIVU; x = 32'd1000; y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush/busy_low", {31'd0, busy}, 32'd0);
        watch_no_done("flush/no_done", 40);
        check("flush/result_held", result, 32'd14);
        run_op("after_flush", OP_DIVU, 32'd1000, 32'd3, 32'd333, LAT_FULL);

        // Flush beats start in the same cycle.
        op = OP_DIVU; x = 32'd50; y = 32'd5; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        check("flush_vs_start/busy", {31'd0, busy}, 32'd0);

        // Start while busy is ignored.
        op = OP_DIVU; x = 32'd100; y = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op = OP_DIVU; x = 32'd50; y = 32'd0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, seen);
        check("start_busy/done_seen", 32'(seen), 32'd1);
        check("start_busy/latency", 32'(lat + 5), 32'(LAT_FULL));
        check("start_busy/result", result, 32'd14);

        // Start in the DONE cycle is ignored.
        op = OP_DIVU; x = 32'd9; y = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_in_done/busy", {31'd0, busy}, 32'd0);
        check("start_in_done/result", result, 32'd14);

        // Reset in the middle of an operation.
        op = OP_DIV; x = 32'd1000; y = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("mid_reset/busy", {31'd0, busy}, 32'd0);
        check("mid_reset/done", {31'd0, done}, 32'd0);
        check("mid_reset/result", result, 32'd0);
        watch_no_done("mid_reset/no_done", 40);

        // Random operations against the reference.
        for (int i = 0; i < 48; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          mode;
            ro   = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = $urandom;
            mode = $urandom_range(0, 7);
            case (mode)
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 1000));
                4: begin ra = 32'($urandom_range(0, 50)); rb = -32'($urandom_range(1, 100)); end
                default: ;
            endcase
            model(ro, ra, rb, exp_res, exp_lat);
            run_op($sformatf("rand%0d_op%0d_%08h_%08h", i, ro, ra, rb), ro, ra, rb, exp_res, exp_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
